fifo_head_driver: RTL and testbench

- Clocked launcher at the head of an asynchronous click-based token FIFO.
- On request, injects a burst of N tokens by toggling a 2-phase drive line into the first async stage.
- Counts returning 2-phase free transitions from the pipeline tail as credits, so at most DEPTH tokens are in flight.
- Reports completion once every launched token has been freed. It is the transmitting end of the drive/free handshake.

---
 rtl/fifo_head_pkg.sv | 15 +
 rtl/toggle_sync.sv | 43 ++++
 rtl/fifo_head_driver.sv | 189 ++++++++++++++++++
 tb/tb_fifo_head_driver.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_head_pkg.sv
// Shared types and constants for the async FIFO head driver.
package fifo_head_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StLaunch = 2'd1,
    StDrain  = 2'd2,
    StDone   = 2'd3
  } state_e;

  // Bit positions inside o_err.
  localparam int unsigned ERR_UNDERFLOW = 0;
  localparam int unsigned ERR_TIMEOUT   = 1;

endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: brings an asynchronous 2-phase toggle line into the clk domain
// and emits a one-cycle pulse for every transition seen on it.
module toggle_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_evt
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   ref_q, ref_d;
  logic                   sync_last;

  assign sync_last = sync_q[SYNC_STAGES-1];

  // Shift the async level in; the reference always tracks the last synced bit.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_async};
    ref_d  = sync_last;
  end

  // Synchronizer chain carries no reset so it keeps following the line during rst.
  always_ff @(posedge clk) begin
    sync_q <= sync_d;
  end

  // Reference loads the synced level during rst too, so leaving reset is silent.
  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q <= sync_last;
    end else begin
      ref_q <= ref_d;
    end
  end

  // Pulse whenever the synced level differs from the reference.
  always_comb begin
    o_evt = ~rst & (sync_last ^ ref_q);
  end

endmodule

// File: rtl/fifo_head_driver.sv
// fifo_head_driver: clocked launcher at the head of a click-based async token
// FIFO. Injects bursts by toggling o_drive, takes credits back from i_free
// toggles and pulses o_done once every launched token has been freed.
// Optional watchdog: define FIFO_HEAD_TIMEOUT_EN.
module fifo_head_driver
  import fifo_head_pkg::*;
#(
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned LEN_W       = 8,
  parameter int unsigned GAP_CYC     = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_start,
  input  logic [LEN_W-1:0]           i_burst_len,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_drive,
  input  logic                       i_free,
  output logic [$clog2(DEPTH+1)-1:0] o_inflight,
  output logic [1:0]                 o_err
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned GapW = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [CntW-1:0] DepthC  = CntW'(DEPTH);
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYC);

  state_e            state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [CntW-1:0]   inflight_q, inflight_d;
  logic              drive_q, drive_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;

  logic free_evt;
  logic launch;
  logic credit_full;
  logic timeout;

  toggle_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_free_sync (
    .clk    (clk),
    .rst    (rst),
    .i_async(i_free),
    .o_evt  (free_evt)
  );

  // Credit check uses the registered count, so a same-cycle free cannot unblock.
  assign credit_full = (inflight_q >= DepthC);
  assign launch      = (state_q == StLaunch) && (gap_q == '0) && !credit_full;

`ifdef FIFO_HEAD_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT_CYC - 1);

  logic [WdW-1:0] wd_q, wd_d;
  logic           wd_count;

  // Watchdog: counts stalled cycles (draining or credit-blocked), cleared by progress.
  always_comb begin
    wd_count = (state_q == StDrain) || ((state_q == StLaunch) && credit_full);
    wd_d     = wd_q;
    timeout  = 1'b0;
    if (launch || free_evt || !wd_count) begin
      wd_d = '0;
    end else if (wd_q == WdLast) begin
      timeout = 1'b1;
      wd_d    = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Watchdog counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout            = 1'b0;
`endif

  // Next-state: FSM, credit counter, gap timer, drive toggle and sticky errors.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    inflight_d  = inflight_q;
    drive_d     = drive_q;
    err_d       = err_q;
    gap_d       = (gap_q != '0) ? gap_q - 1'b1 : '0;
    busy_d      = (state_q == StLaunch) || (state_q == StDrain);
    done_d      = (state_q == StDone);

    // A launch and a free in the same cycle cancel out.
    case ({launch, free_evt})
      2'b10: inflight_d = inflight_q + 1'b1;
      2'b01: begin
        if (inflight_q == '0) begin
          err_d[ERR_UNDERFLOW] = 1'b1;
        end else begin
          inflight_d = inflight_q - 1'b1;
        end
      end
      default: ;
    endcase

    if (launch) begin
      drive_d     = ~drive_q;
      remaining_d = remaining_q - 1'b1;
      gap_d       = GapLoad;
    end

    case (state_q)
      StIdle: begin
        if (i_start) begin
          if (i_burst_len != '0) begin
            remaining_d = i_burst_len;
            state_d     = StLaunch;
          end else begin
            state_d = StDone;
          end
        end
      end
      StLaunch: begin
        if (launch && (remaining_q == LEN_W'(1))) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (inflight_q == '0) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Watchdog expiry abandons the outstanding credits and completes the burst.
    if (timeout) begin
      err_d[ERR_TIMEOUT] = 1'b1;
      inflight_d         = '0;
      state_d            = StDone;
    end
`ifndef FIFO_HEAD_TIMEOUT_EN
    err_d[ERR_TIMEOUT] = 1'b0;
`endif
  end

  // State and output registers; synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      gap_q       <= '0;
      inflight_q  <= '0;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      gap_q       <= gap_d;
      inflight_q  <= inflight_d;
      drive_q     <= drive_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_busy     = busy_q;
  assign o_done     = done_q;
  assign o_drive    = drive_q;
  assign o_inflight = inflight_q;
  assign o_err      = err_q;

endmodule

// File: tb/tb_fifo_head_driver.sv
// Testbench for fifo_head_driver: behavioural model compared every cycle, a
// tail responder that frees launched tokens, directed scenarios and random bursts.
module tb_fifo_head_driver;

  localparam int unsigned DEPTH       = 2;
  localparam int unsigned LEN_W       = 8;
  localparam int unsigned GAP_CYC     = 2;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned TIMEOUT_CYC = 16;
  localparam int unsigned CntW        = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             i_start;
  logic [LEN_W-1:0] i_burst_len;
  logic             o_busy;
  logic             o_done;
  logic             o_drive;
  logic             i_free;
  logic [CntW-1:0]  o_inflight;
  logic [1:0]       o_err;

  fifo_head_driver #(
    .DEPTH      (DEPTH),
    .LEN_W      (LEN_W),
    .GAP_CYC    (GAP_CYC),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_burst_len(i_burst_len),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_drive    (o_drive),
    .i_free     (i_free),
    .o_inflight (o_inflight),
    .o_err      (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A burst is "on" while tokens remain to launch or credits remain outstanding;
  // a pending completion produces the done pulse one registered cycle later.
  bit m_on, m_pend, m_busy, m_done, m_drive;
  int m_left, m_infl, m_gap, m_wd;
  bit [1:0] m_err;
  bit fh [0:SYNC_STAGES];
  bit fevt, mlaunch, counting;
  int infl0;

  initial for (int k = 0; k <= SYNC_STAGES; k++) fh[k] = 1'b0;

  always @(posedge clk) begin
    // i_free seen SYNC_STAGES edges ago versus one edge earlier.
    fevt = (fh[SYNC_STAGES-1] != fh[SYNC_STAGES]);
    for (int k = SYNC_STAGES; k > 0; k--) fh[k] = fh[k-1];
    fh[0] = i_free;
    if (rst) begin
      m_on = 0; m_pend = 0; m_busy = 0; m_done = 0; m_drive = 0;
      m_left = 0; m_infl = 0; m_gap = 0; m_wd = 0; m_err = 2'b00;
    end else begin
      infl0    = m_infl;
      mlaunch  = m_on && (m_left > 0) && (m_gap == 0) && (infl0 < DEPTH);
      counting = m_on && ((m_left == 0) || (infl0 >= DEPTH));
      m_busy   = m_on;
      m_done   = m_pend;
      if (mlaunch && !fevt) m_infl = m_infl + 1;
      else if (fevt && !mlaunch) begin
        if (m_infl == 0) m_err[0] = 1'b1;
        else m_infl = m_infl - 1;
      end
      m_gap = mlaunch ? GAP_CYC : ((m_gap > 0) ? m_gap - 1 : 0);
      if (m_pend) m_pend = 0;
      else if (!m_on) begin
        if (i_start) begin
          if (i_burst_len == 0) m_pend = 1;
          else begin m_on = 1; m_left = i_burst_len; end
        end
      end else if (m_left > 0) begin
        if (mlaunch) begin m_drive = ~m_drive; m_left = m_left - 1; end
      end else if (infl0 == 0) begin
        m_on = 0; m_pend = 1;
      end
`ifdef FIFO_HEAD_TIMEOUT_EN
      if (mlaunch || fevt || !counting) m_wd = 0;
      else if (m_wd == TIMEOUT_CYC - 1) begin
        m_wd = 0; m_err[1] = 1'b1; m_infl = 0; m_on = 0; m_left = 0; m_pend = 1;
      end else m_wd = m_wd + 1;
`endif
    end
    #1;
    check("busy", o_busy, m_busy);
    check("done", o_done, m_done);
    check("drive", o_drive, m_drive);
    check("inflight", o_inflight, m_infl);
    check("err", o_err, m_err);
  end

  // ---------------- stimulus / tail responder ----------------
  int cyc = 0;
  int launches, done_cnt, max_infl;
  int last_launch_cyc, first_launch_cyc, last_free_cyc, done_cyc;
  bit last_drive, stall, resp_rand, busy_seen;
  int dueq[$];

  // Advance to the next negedge, observe outputs and play the tail side.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rst) last_drive = o_drive;
    else if (o_drive != last_drive) begin
      last_drive = o_drive;
      launches++;
      if (launches == 1) first_launch_cyc = cyc;
      last_launch_cyc = cyc;
      dueq.push_back(cyc + (resp_rand ? int'($urandom_range(1, 12)) : 6));
    end
    if (int'(o_inflight) > max_infl) max_infl = o_inflight;
    if (o_busy) busy_seen = 1;
    if (o_done) begin done_cnt++; done_cyc = cyc; end
    if (!stall && !rst && dueq.size() > 0 && dueq[0] <= cyc) begin
      i_free = ~i_free;
      last_free_cyc = cyc;
      void'(dueq.pop_front());
    end
  endtask

  task automatic clear_stats();
    launches = 0; done_cnt = 0; max_infl = 0; busy_seen = 0;
  endtask

  task automatic start_burst(input int len);
    i_start = 1'b1;
    i_burst_len = LEN_W'(len);
    tick();
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    bit got = 0;
    for (int n = 0; n < limit && !got; n++) begin
      tick();
      if (o_done) got = 1;
    end
    check(name, got, 1);
  endtask

  task automatic wait_launches(input int want, input string name);
    for (int n = 0; n < 100 && launches < want; n++) tick();
    check(name, launches, want);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dueq.delete();
    repeat (4) tick();
    rst = 1'b0;
    tick();
  endtask

  int s_cyc, rel_cyc, len;
  bit got;

  initial begin
    rst = 1'b1; i_start = 1'b0; i_burst_len = '0; i_free = 1'b0;
    stall = 0; resp_rand = 0; last_drive = 0;
    clear_stats();
    repeat (5) tick();
    check("reset_busy", o_busy, 0);
    check("reset_done", o_done, 0);
    check("reset_drive", o_drive, 0);
    check("reset_inflight", o_inflight, 0);
    check("reset_err", o_err, 0);
    rst = 1'b0;
    tick();

    // Burst of 5 with the tail freeing each token 6 cycles after launch.
    clear_stats();
    start_burst(5);
    s_cyc = cyc;
    wait_done(300, "burst5_done_seen");
    repeat (4) tick();
    check("burst5_first_launch_latency", first_launch_cyc - s_cyc, 1);
    check("burst5_toggles", launches, 5);
    check("burst5_max_inflight", max_infl, 2);
    check("burst5_done_count", done_cnt, 1);
    check("burst5_done_after_last_free", done_cyc - last_free_cyc, 5);
    check("burst5_err", o_err, 0);

    // Burst of 3 with frees withheld: credit blocks the third launch.
    clear_stats();
    stall = 1;
    start_burst(3);
    wait_launches(2, "stall_two_launches");
    repeat (8) tick();
    check("stall_drive_holds", launches, 2);
    check("stall_inflight_full", o_inflight, 2);
    stall = 0;
    tick();
    rel_cyc = last_free_cyc;
    wait_launches(3, "stall_third_launch");
    check("stall_third_launch_delay", last_launch_cyc - rel_cyc, 4);
    wait_done(200, "stall_done_seen");

    // Zero-length burst completes without launching.
    repeat (2) tick();
    clear_stats();
    start_burst(0);
    s_cyc = cyc;
    check("len0_no_done_yet", o_done, 0);
    tick();
    check("len0_done_cycle2", o_done, 1);
    tick();
    check("len0_done_single", o_done, 0);
    check("len0_no_toggles", launches, 0);
    check("len0_busy_never", busy_seen, 0);

    // Free toggle with nothing in flight flags underflow.
    repeat (3) tick();
    i_free = ~i_free;
    repeat (6) tick();
    check("underflow_err", o_err, 1);
    check("underflow_inflight", o_inflight, 0);
    repeat (5) tick();
    check("underflow_sticky", o_err[0], 1);
    do_reset();
    check("underflow_cleared", o_err, 0);

    // Reset mid-burst with i_free held high.
    clear_stats();
    stall = 1;
    start_burst(5);
    repeat (10) tick();
    rst = 1'b1;
    i_free = 1'b1;
    dueq.delete();
    repeat (4) tick();
    check("midrst_busy", o_busy, 0);
    check("midrst_drive", o_drive, 0);
    check("midrst_inflight", o_inflight, 0);
    check("midrst_err", o_err, 0);
    rst = 1'b0;
    stall = 0;
    repeat (8) tick();
    check("midrst_after_err", o_err, 0);
    check("midrst_after_inflight", o_inflight, 0);
    check("midrst_after_done", done_cnt, 0);

`ifdef FIFO_HEAD_TIMEOUT_EN
    // Watchdog expiry with frees withheld.
    clear_stats();
    stall = 1;
    start_burst(3);
    wait_launches(2, "timeout_two_launches");
    wait_done(60, "timeout_done_seen");
    check("timeout_done_delay", done_cyc - last_launch_cyc, 17);
    check("timeout_err", o_err, 2);
    check("timeout_inflight", o_inflight, 0);
    stall = 0;
    do_reset();
`endif

    // Random bursts with random tail latency and ignored restarts while busy.
    resp_rand = 1;
    for (int b = 0; b < 30; b++) begin
      clear_stats();
      len = $urandom_range(0, 7);
      start_burst(len);
      got = 0;
      for (int n = 0; n < 400 && !got; n++) begin
        if (o_busy && $urandom_range(0, 15) == 0) begin
          i_start = 1'b1;
          i_burst_len = LEN_W'($urandom_range(1, 255));
        end
        tick();
        i_start = 1'b0;
        if (o_done) got = 1;
      end
      check("rand_done_seen", got, 1);
      check("rand_toggles", launches, len);
      repeat ($urandom_range(0, 3)) tick();
    end
    check("rand_err_clean", o_err, 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_time_limit: simulation did not finish, %0d errors so far", errors);
    $fatal(1);
  end

endmodule
